sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single read-only Sram port between two requesters: instruction fetch (IFU, id 0) and load/store unit (LSU, id 1).
- Each requester has a valid/ready request channel and a valid/ready response channel. The block sequences the Sram req/ready protocol, routes returned data to the owner, and bounds each access with a timeout.
- Sits between the IFU/LSU and the Sram instance in the npc core.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 15, max WAIT-state cycles without sram_ready before an error response; must be ≥1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ifu_req_valid  in  1  IFU request pending
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  IFU read address
- ifu_resp_valid  out  1  IFU response available
- ifu_resp_ready  in  1  IFU consumes response
- ifu_resp_data  out  DATA_W  IFU read data
- ifu_resp_err  out  1  IFU access timed out
- lsu_req_valid, lsu_req_ready, lsu_addr, lsu_resp_valid, lsu_resp_ready, lsu_resp_data, lsu_resp_err: same directions, widths and meanings for the LSU
- sram_req  out  1  Sram request strobe
- sram_addr  out  ADDR_W  Sram address
- sram_ready  in  1  Sram data valid, one cycle after the sampled sram_req
- sram_data  in  DATA_W  Sram read data

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high. While rst=1, all state returns to IDLE and every output reads 0.
- Reset values: state=IDLE, owner=0, last_grant=1 (LSU), timeout counter=0, latched addr/data=0, sram_req=0, sram_addr=0, all *_req_ready/*_resp_valid/*_resp_err=0, resp_data=0.
- IDLE:
  - Arbitration is combinational over the two req_valid inputs.
  - Single requester: it is granted.
  - Both requesting: grant the one that is not last_grant (round-robin).
  - The granted requester's req_ready=1 in the same cycle; the handshake completes.
  - On handshake: latch addr, set owner and last_grant, go to ISSUE.
  - req_ready is 0 in every other state.
- ISSUE:
  - sram_req=1 and sram_addr=latched addr for exactly one cycle.
  - Go to WAIT and clear the counter.
  - sram_req is never held high for more than one cycle, so Sram ready pulses once.
- WAIT:
  - sram_req=0; sram_addr holds the latched addr.
  - If sram_ready=1: latch sram_data, err=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without ready: data=0, err=1, go to RESP.
  - If ready arrives in the same cycle the counter reaches TIMEOUT-1, ready wins (err=0).
- RESP:
  - The owner's resp_valid=1, with resp_data and resp_err driven from latches. The non-owner's resp_* stay 0.
  - Hold until the owner's resp_ready=1, then go to IDLE. resp_valid drops in the IDLE cycle.
- Latency: accept at cycle T → sram_req at T+1 → sram_ready at T+2 → resp_valid at T+3. Minimum 4 cycles per transaction with resp_ready tied high.
- Boundary cases:
  - sram_ready or sram_data outside WAIT: ignored.
  - req_valid dropping after acceptance: no effect.
  - A requester may hold req_valid during its own RESP; it is re-arbitrated in IDLE.
  - rst during any state aborts the transaction: no response is issued, and a later stray sram_ready is ignored.
- Width rules: addr/data are passed unmodified; no alignment check. The counter is $clog2(TIMEOUT+1) bits and saturates, never wrapping.

Decomposition:
- Package sram_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - requester ids REQ_IFU=0, REQ_LSU=1
- One sub-module, sram_arb_rr: 2-way round-robin picker.
  - Inputs: two valids, last_grant.
  - Outputs: grant_valid, grant_id.
  - Purely combinational.
- The FSM, latches and timeout counter stay in sram_arbiter.

Test Plan:
- Single IFU read: ifu addr=0x80000000 and Sram returns 0x00000413 → sram_req pulses one cycle at T+1, ifu_resp_valid at T+3 with data 0x00000413, err=0, lsu_resp_valid stays 0.
- Contention: IFU (0x80000004) and LSU (0x80000100) both valid from reset → IFU granted first, then LSU, then IFU again. Grant order alternates 0,1,0,1 over 4 transactions.
- Response backpressure: LSU resp_ready held 0 for 5 cycles → lsu_resp_valid and data stay stable; no new sram_req; IFU req_ready=0 throughout.
- Timeout: Sram model never asserts ready → resp_valid after TIMEOUT WAIT cycles, err=1, data=0; the next transaction completes normally.
- Reset mid-op: rst=1 in WAIT, with sram_ready=1 on the next cycle → all outputs 0, state IDLE, no resp_valid to either requester.
- Stray ready: sram_ready=1 while IDLE with data 0xDEADBEEF → no response; subsequent read returns its correct data.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types for the two-requester Sram arbiter.
// Requester ids also index the round-robin picker and the owner register.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_e;

    localparam logic REQ_IFU = 1'b0;
    localparam logic REQ_LSU = 1'b1;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester and Sram-side signals of the arbiter, bundled as one interface.
// The slave view belongs to the arbiter; the master view belongs to its environment.
interface sram_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);

    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_resp_valid;
    logic              ifu_resp_ready;
    logic [DATA_W-1:0] ifu_resp_data;
    logic              ifu_resp_err;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic              lsu_resp_valid;
    logic              lsu_resp_ready;
    logic [DATA_W-1:0] lsu_resp_data;
    logic              lsu_resp_err;

    logic              sram_req;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_ready;
    logic [DATA_W-1:0] sram_data;

    modport slave (
        input  ifu_req_valid, ifu_addr, ifu_resp_ready,
        input  lsu_req_valid, lsu_addr, lsu_resp_ready,
        input  sram_ready, sram_data,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
        output sram_req, sram_addr
    );

    modport master (
        output ifu_req_valid, ifu_addr, ifu_resp_ready,
        output lsu_req_valid, lsu_addr, lsu_resp_ready,
        output sram_ready, sram_data,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
        input  sram_req, sram_addr
    );

endinterface

// File: rtl/sram_arb_rr.sv
// Combinational 2-way round-robin picker: a lone requester always wins,
// contention goes to whichever requester was not granted last.
module sram_arb_rr
    import sram_arb_pkg::*;
(
    input  logic ifu_valid,
    input  logic lsu_valid,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = ifu_valid | lsu_valid;
        grant_id    = REQ_IFU;
        if (ifu_valid && lsu_valid) begin
            grant_id = ~last_grant;
        end else if (lsu_valid) begin
            grant_id = REQ_LSU;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one read-only Sram port between IFU and LSU: arbitrates, issues a one-cycle
// Sram request, waits (bounded by TIMEOUT) for data and returns it to the owner.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input logic           clk,
    input logic           rst,
    sram_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    logic grant_valid;
    logic grant_id;
    logic ifu_accept;
    logic lsu_accept;
    logic issue;
    logic owner_resp_ready;
    logic resp_valid;

    sram_arb_rr u_rr (
        .ifu_valid   (bus.ifu_req_valid),
        .lsu_valid   (bus.lsu_req_valid),
        .last_grant  (last_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign owner_resp_ready = (owner_q == REQ_IFU) ? bus.ifu_resp_ready : bus.lsu_resp_ready;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        err_d      = err_q;
        ifu_accept = 1'b0;
        lsu_accept = 1'b0;
        issue      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    if (grant_id == REQ_IFU) begin
                        ifu_accept = 1'b1;
                        addr_d     = bus.ifu_addr;
                    end else begin
                        lsu_accept = 1'b1;
                        addr_d     = bus.lsu_addr;
                    end
                    owner_d = grant_id;
                    last_d  = grant_id;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                issue   = 1'b1;
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A ready arriving on the final count still wins over the timeout.
                if (bus.sram_ready) begin
                    data_d  = bus.sram_data;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RESP: begin
                if (owner_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= REQ_IFU;
            last_q  <= REQ_LSU;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Outputs are forced low while rst is high, even before the state has settled.
    assign resp_valid = ~rst & (state_q == RESP);

    assign bus.ifu_req_ready  = ~rst & ifu_accept;
    assign bus.lsu_req_ready  = ~rst & lsu_accept;
    assign bus.sram_req       = ~rst & issue;
    assign bus.sram_addr      = rst ? '0 : addr_q;

    assign bus.ifu_resp_valid = resp_valid & (owner_q == REQ_IFU);
    assign bus.ifu_resp_data  = bus.ifu_resp_valid ? data_q : '0;
    assign bus.ifu_resp_err   = bus.ifu_resp_valid & err_q;

    assign bus.lsu_resp_valid = resp_valid & (owner_q == REQ_LSU);
    assign bus.lsu_resp_data  = bus.lsu_resp_valid ? data_q : '0;
    assign bus.lsu_resp_err   = bus.lsu_resp_valid & err_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-timing model of the arbiter kept in the bench.
module tb_sram_arbiter;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Stimulus knobs
    int          new_pct   = 0;
    int          rr_pct[2] = '{100, 100};
    int          stray_pct = 0;
    int          fix_delay = -1;   // -1 random, -2 Sram never answers, >=0 fixed extra delay
    logic        fix_data_en = 1'b0;
    logic [31:0] fix_data    = '0;
    logic        force_ready = 1'b0;
    logic [31:0] force_data  = '0;
    logic        hold_req    = 1'b0;

    // Requester state
    logic        pend[2];
    logic [31:0] paddr[2];

    // Model: one transaction in flight, described by its age in cycles since acceptance
    logic        m_busy;
    logic        m_owner;
    logic        m_last;
    logic        m_err;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    int          m_age;
    int          m_ready_age;
    int          m_resp_age;

    int grants[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bound_fail(input string tag);
        failures++;
        $error("FAIL %s observed=bound_expired expected=event", tag);
    endtask

    task automatic post(input int id, input logic [31:0] addr);
        pend[id]  = 1'b1;
        paddr[id] = addr;
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_last = 1'b1;
        m_addr = '0;
    endtask

    task automatic accept(input logic id);
        int d;
        m_busy  = 1'b1;
        m_owner = id;
        m_last  = id;
        m_addr  = paddr[id];
        m_age   = 1;
        if (!hold_req) pend[id] = 1'b0;
        if (fix_delay == -1) begin
            d = $urandom_range(9);
            if (d <= 5) d = 0;
            else if (d == 6) d = 1;
            else if (d == 7) d = 2;
            else if (d == 8) d = TIMEOUT - 1;
            else d = -2;
        end else begin
            d = fix_delay;
        end
        if (d == -2) begin
            m_ready_age = -1;
            m_resp_age  = TIMEOUT + 2;
            m_err       = 1'b1;
            m_data      = '0;
        end else begin
            m_ready_age = 2 + d;
            m_resp_age  = 3 + d;
            m_err       = 1'b0;
            m_data      = fix_data_en ? fix_data : $urandom;
        end
    endtask

    // One clock cycle: drive at posedge+1, check at posedge+5, update the model, advance.
    task automatic run_cycle();
        logic exp_rdy[2];
        logic exp_rv[2];
        logic exp_req;
        logic g_valid;
        logic g_id;
        logic in_wait;
        logic rready[2];

        in_wait = m_busy && (m_age >= 2) && (m_age < m_resp_age);
        if (m_busy && m_age == m_ready_age) begin
            bus.sram_ready = 1'b1;
            bus.sram_data  = m_data;
        end else if (force_ready) begin
            bus.sram_ready = 1'b1;
            bus.sram_data  = force_data;
        end else if (!in_wait && $urandom_range(99) < stray_pct) begin
            bus.sram_ready = 1'b1;
            bus.sram_data  = $urandom;
        end else begin
            bus.sram_ready = 1'b0;
            bus.sram_data  = $urandom;
        end

        for (int r = 0; r < 2; r++) begin
            if (!pend[r] && $urandom_range(99) < new_pct) post(r, $urandom);
            rready[r] = ($urandom_range(99) < rr_pct[r]);
        end
        bus.ifu_req_valid  = pend[0];
        bus.ifu_addr       = pend[0] ? paddr[0] : $urandom;
        bus.lsu_req_valid  = pend[1];
        bus.lsu_addr       = pend[1] ? paddr[1] : $urandom;
        bus.ifu_resp_ready = rready[0];
        bus.lsu_resp_ready = rready[1];

        #4;
        exp_rdy = '{1'b0, 1'b0};
        exp_rv  = '{1'b0, 1'b0};
        exp_req = 1'b0;
        g_valid = 1'b0;
        g_id    = 1'b0;
        if (!rst) begin
            if (!m_busy) begin
                g_valid = pend[0] | pend[1];
                g_id    = (pend[0] && pend[1]) ? ~m_last : pend[1];
                if (g_valid) exp_rdy[g_id] = 1'b1;
            end else begin
                exp_req = (m_age == 1);
                if (m_age >= m_resp_age) exp_rv[m_owner] = 1'b1;
            end
        end

        chk("ifu_req_ready", bus.ifu_req_ready, exp_rdy[0]);
        chk("lsu_req_ready", bus.lsu_req_ready, exp_rdy[1]);
        chk("sram_req", bus.sram_req, exp_req);
        chk("ifu_resp_valid", bus.ifu_resp_valid, exp_rv[0]);
        chk("lsu_resp_valid", bus.lsu_resp_valid, exp_rv[1]);
        if (rst) begin
            chk("rst_sram_addr", bus.sram_addr, 0);
            chk("rst_ifu_data", bus.ifu_resp_data, 0);
            chk("rst_lsu_data", bus.lsu_resp_data, 0);
            chk("rst_ifu_err", bus.ifu_resp_err, 0);
            chk("rst_lsu_err", bus.lsu_resp_err, 0);
        end else if (m_busy) begin
            if (m_age >= 1 && m_age < m_resp_age) chk("sram_addr", bus.sram_addr, m_addr);
            if (m_age >= m_resp_age) begin
                chk("ifu_resp_data", bus.ifu_resp_data, exp_rv[0] ? m_data : 32'h0);
                chk("ifu_resp_err", bus.ifu_resp_err, exp_rv[0] ? m_err : 1'b0);
                chk("lsu_resp_data", bus.lsu_resp_data, exp_rv[1] ? m_data : 32'h0);
                chk("lsu_resp_err", bus.lsu_resp_err, exp_rv[1] ? m_err : 1'b0);
            end
        end
        if (bus.ifu_req_ready) grants.push_back(0);
        if (bus.lsu_req_ready) grants.push_back(1);

        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            if (g_valid) accept(g_id);
        end else if (m_age >= m_resp_age && rready[m_owner]) begin
            m_busy = 1'b0;
        end else begin
            m_age++;
        end

        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        new_pct   = 0;
        stray_pct = 0;
        rr_pct    = '{100, 100};
        n = 0;
        while ((m_busy || pend[0] || pend[1]) && n < 200) begin
            run_cycle();
            n++;
        end
        if (m_busy || pend[0] || pend[1]) bound_fail("drain");
        run_cycle();
    endtask

    initial begin
        int n;
        rst                = 1'b1;
        bus.ifu_req_valid  = 1'b0;
        bus.ifu_addr       = '0;
        bus.ifu_resp_ready = 1'b0;
        bus.lsu_req_valid  = 1'b0;
        bus.lsu_addr       = '0;
        bus.lsu_resp_ready = 1'b0;
        bus.sram_ready     = 1'b0;
        bus.sram_data      = '0;
        pend               = '{1'b0, 1'b0};
        paddr              = '{32'h0, 32'h0};
        model_reset();
        @(posedge clk);
        #1;

        // Contention from reset: both requests held through reset, grants alternate.
        post(0, 32'h8000_0004);
        post(1, 32'h8000_0100);
        hold_req    = 1'b1;
        fix_delay   = 0;
        run_cycle();
        run_cycle();
        rst = 1'b0;
        n = 0;
        while (grants.size() < 4 && n < 60) begin
            run_cycle();
            n++;
        end
        hold_req = 1'b0;
        pend     = '{1'b0, 1'b0};
        chk("grant_count", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            chk($sformatf("grant_order[%0d]", i), grants[i], i % 2);
        drain();

        // Single IFU read with the canonical data word.
        fix_data_en = 1'b1;
        fix_data    = 32'h0000_0413;
        post(0, 32'h8000_0000);
        drain();

        // LSU response backpressure while IFU waits.
        fix_data = 32'hCAFE_0001;
        rr_pct   = '{100, 0};
        post(1, 32'h8000_0200);
        n = 0;
        while (!m_busy && n < 10) begin
            run_cycle();
            n++;
        end
        post(0, 32'h8000_0008);
        n = 0;
        while (m_busy && m_age < m_resp_age && n < 20) begin
            run_cycle();
            n++;
        end
        if (!m_busy || m_age < m_resp_age) bound_fail("backpressure_resp");
        repeat (5) run_cycle();
        rr_pct = '{100, 100};
        drain();

        // Timeout, then a normal read; then ready landing on the last count.
        fix_delay = -2;
        post(0, 32'h8000_0010);
        drain();
        fix_delay = 0;
        fix_data  = 32'h1111_2222;
        post(1, 32'h8000_0014);
        drain();
        fix_delay = TIMEOUT - 1;
        fix_data  = 32'h3333_4444;
        post(1, 32'h8000_0018);
        drain();

        // Reset in WAIT with a late ready right after; nothing may come back.
        fix_delay = 5;
        post(0, 32'h8000_0020);
        n = 0;
        while (!(m_busy && m_age == 2) && n < 10) begin
            run_cycle();
            n++;
        end
        rst = 1'b1;
        run_cycle();
        rst         = 1'b0;
        force_ready = 1'b1;
        force_data  = 32'hDEAD_BEEF;
        run_cycle();
        force_ready = 1'b0;
        repeat (3) run_cycle();

        // Stray ready while idle, then a read must return its own data.
        force_ready = 1'b1;
        run_cycle();
        force_ready = 1'b0;
        fix_delay   = 0;
        fix_data    = 32'h1234_5678;
        post(1, 32'h8000_0030);
        drain();

        // Random traffic with stray readies, backpressure, timeouts and rare resets.
        fix_delay   = -1;
        fix_data_en = 1'b0;
        new_pct     = 30;
        rr_pct      = '{70, 70};
        stray_pct   = 20;
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(299) == 0);
            run_cycle();
        end
        rst = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
